// File: rtl/ghost_dir_gen.sv
// ghost_dir_gen: LFSR-driven direction picker for one ghost.
// Ports: Clk, Reset(n), frame_tick, sec, restart, map*, ghostX/Y -> randomkeycode, dir_changed.
module ghost_dir_gen #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          HOLD_FRAMES = 60,
  parameter int          TUN_Y_MIN   = 195,
  parameter int          TUN_Y_MAX   = 223,
  parameter int          TUN_X_LO    = 10,
  parameter int          TUN_X_HI    = 390
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       sec,
  input  logic       restart,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  output logic [7:0] randomkeycode,
  output logic       dir_changed
);

  typedef enum logic [1:0] {
    S_HOLD, S_MOVE, S_CHOOSE, S_FALL
  } state_t;

  localparam logic [15:0] SEED_EFF =
    (SEED == 16'd0) ? 16'd1 : SEED;
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_FRAMES);
  localparam logic [9:0]  YMIN = 10'(TUN_Y_MIN);
  localparam logic [9:0]  YMAX = 10'(TUN_Y_MAX);
  localparam logic [9:0]  XLO  = 10'(TUN_X_LO);
  localparam logic [9:0]  XHI  = 10'(TUN_X_HI);

  localparam logic [7:0] C_LEFT  = 8'h1A;
  localparam logic [7:0] C_UP    = 8'h16;
  localparam logic [7:0] C_RIGHT = 8'h04;
  localparam logic [7:0] C_DOWN  = 8'h07;
  localparam logic [7:0] C_NONE  = 8'h00;

  function automatic logic [7:0] code_of(input logic [1:0] i);
    logic [7:0] c;
    case (i)
      2'd0:    c = C_LEFT;
      2'd1:    c = C_UP;
      2'd2:    c = C_RIGHT;
      default: c = C_DOWN;
    endcase
    return c;
  endfunction

  state_t      state, state_nx;
  logic [15:0] lfsr;
  logic [15:0] hold_cnt, hold_nx;
  logic [1:0]  k, k_nx;
  logic [1:0]  start, start_nx;
  logic [7:0]  code_nx;

  logic        cur_vld;
  logic [1:0]  cur_idx;
  logic [1:0]  rev;
  logic [1:0]  cand;
  logic [3:0]  open;
  logic        cand_ok;
  logic        tunnel;
  logic        trig;
  logic        fb;

  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    cur_vld = 1'b1;
    cur_idx = 2'd0;
    unique case (1'b1)
      (randomkeycode == C_LEFT):  cur_idx = 2'd0;
      (randomkeycode == C_UP):    cur_idx = 2'd1;
      (randomkeycode == C_RIGHT): cur_idx = 2'd2;
      (randomkeycode == C_DOWN):  cur_idx = 2'd3;
      default:                    cur_vld = 1'b0;
    endcase
  end

  assign open = {mapB == 5'd0, mapR == 5'd0,
                 mapT == 5'd0, mapL == 5'd0};
  assign rev  = cur_idx + 2'd2;
  assign cand = start + k;
  assign cand_ok = open[cand] && !(cur_vld && cand == rev);

  assign tunnel = (ghostY >= YMIN) && (ghostY <= YMAX) &&
                  ((ghostX <= XLO) || (ghostX >= XHI));

  // A sec pulse always forces a fresh pick; a frame tick only
  // re-decides when the current heading is blocked or idle.
  assign trig = (frame_tick || sec) && !tunnel &&
                (!cur_vld || !open[cur_idx] || sec);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)       state <= S_HOLD;
    else if (restart) state <= S_HOLD;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_HOLD:
        if (frame_tick && hold_cnt <= 16'd1)
          state_nx = S_CHOOSE;
      S_MOVE:
        if (trig) state_nx = S_CHOOSE;
      S_CHOOSE:
        if (cand_ok)        state_nx = S_MOVE;
        else if (k == 2'd3) state_nx = S_FALL;
      S_FALL:
        state_nx = S_MOVE;
      default:
        state_nx = S_HOLD;
    endcase
  end

  always_comb begin
    code_nx  = randomkeycode;
    hold_nx  = hold_cnt;
    k_nx     = k;
    start_nx = start;
    unique case (state)
      S_HOLD:
        if (frame_tick) begin
          if (hold_cnt <= 16'd1) begin
            start_nx = lfsr[1:0];
            k_nx     = 2'd0;
          end else begin
            hold_nx = hold_cnt - 16'd1;
          end
        end
      S_MOVE:
        if (trig) begin
          start_nx = lfsr[1:0];
          k_nx     = 2'd0;
        end
      S_CHOOSE:
        if (cand_ok) code_nx = code_of(cand);
        else         k_nx    = k + 2'd1;
      S_FALL:
        code_nx = (cur_vld && open[rev]) ?
                  code_of(rev) : C_NONE;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lfsr          <= SEED_EFF;
      hold_cnt      <= HOLD_INIT;
      k             <= 2'd0;
      start         <= 2'd0;
      randomkeycode <= C_NONE;
      dir_changed   <= 1'b0;
    end else if (restart) begin
      lfsr          <= SEED_EFF;
      hold_cnt      <= HOLD_INIT;
      k             <= 2'd0;
      start         <= 2'd0;
      randomkeycode <= C_NONE;
      dir_changed   <= 1'b0;
    end else begin
      lfsr          <= {lfsr[14:0], fb};
      hold_cnt      <= hold_nx;
      k             <= k_nx;
      start         <= start_nx;
      randomkeycode <= code_nx;
      dir_changed   <= (code_nx != randomkeycode);
    end
  end

endmodule

// File: tb/tb_ghost_dir_gen.sv
// tb_ghost_dir_gen: scoreboard bench for ghost_dir_gen.
// Predicts each decision at trigger time, checks it at the due cycle.
module tb_ghost_dir_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       sec = 1'b0;
  logic       restart = 1'b0;
  logic [4:0] mapL = '0, mapR = '0, mapB = '0, mapT = '0;
  logic [9:0] ghostX = 10'd200, ghostY = 10'd100;
  logic [7:0] randomkeycode;
  logic       dir_changed;

  ghost_dir_gen #(.SEED(SEED)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .sec(sec), .restart(restart),
    .mapL(mapL), .mapR(mapR), .mapB(mapB), .mapT(mapT),
    .ghostX(ghostX), .ghostY(ghostY),
    .randomkeycode(randomkeycode), .dir_changed(dir_changed)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [15:0] lfsr_m;
  always @(posedge Clk or negedge Reset) begin
    if (!Reset)       lfsr_m <= SEED;
    else if (restart) lfsr_m <= SEED;
    else lfsr_m <= {lfsr_m[14:0],
                    lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  typedef struct {
    logic [7:0] code;
    logic [7:0] prev;
    int         lat;
  } exp_t;
  exp_t sb[$];

  logic [7:0] cur = 8'h00;

  function automatic logic [7:0] dcode(input int i);
    case (i & 3)
      0: return 8'h1A;
      1: return 8'h16;
      2: return 8'h04;
      default: return 8'h07;
    endcase
  endfunction

  function automatic int didx(input logic [7:0] c);
    case (c)
      8'h1A: return 0;
      8'h16: return 1;
      8'h04: return 2;
      8'h07: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit is_open(input int i);
    case (i & 3)
      0: return mapL == 0;
      1: return mapT == 0;
      2: return mapR == 0;
      default: return mapB == 0;
    endcase
  endfunction

  task automatic predict(input logic [1:0] st,
                         input logic [7:0] c0,
                         output logic [7:0] code,
                         output int lat);
    int ci;
    int rv;
    ci = didx(c0);
    rv = (ci + 2) & 3;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (st + k) & 3;
      if (is_open(c) && !(ci >= 0 && c == rv)) begin
        code = dcode(c);
        lat = k + 2;
        return;
      end
    end
    lat = 6;
    code = (ci >= 0 && is_open(rv)) ? dcode(rv) : 8'h00;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    e = sb.pop_front();
    for (int i = 1; i < e.lat - 1; i++) @(negedge Clk);
    check({tag, "_pre"}, randomkeycode, e.prev);
    @(negedge Clk);
    check({tag, "_code"}, randomkeycode, e.code);
    check({tag, "_dc"}, dir_changed, e.code != e.prev);
    cur = e.code;
    @(negedge Clk);
    check({tag, "_dc_end"}, dir_changed, 1'b0);
  endtask

  task automatic fire(input bit use_sec, input bit use_ft,
                      input string tag);
    exp_t e;
    @(negedge Clk);
    predict(lfsr_m[1:0], cur, e.code, e.lat);
    e.prev = cur;
    sb.push_back(e);
    sec = use_sec;
    frame_tick = use_ft;
    @(negedge Clk);
    sec = 1'b0;
    frame_tick = 1'b0;
    drain(tag);
  endtask

  task automatic set_maps(input logic [4:0] l, t, r, b);
    mapL = l; mapT = t; mapR = r; mapB = b;
  endtask

  task automatic do_hold(input int gap, input string tag);
    for (int t = 1; t < 60; t++) begin
      repeat (gap) @(negedge Clk);
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      if (t == 1 || t == 59)
        check({tag, "_hold"}, randomkeycode, 8'h00);
    end
    repeat (gap) @(negedge Clk);
    fire(1'b0, 1'b1, {tag, "_first"});
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    @(negedge Clk);
    check({tag, "_code"}, randomkeycode, 8'h00);
    check({tag, "_dc"}, dir_changed, 1'b0);
    restart = 1'b0;
    cur = 8'h00;
  endtask

  logic [7:0] run_a [5];

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_code", randomkeycode, 8'h00);
    check("rst_dc", dir_changed, 1'b0);
    Reset = 1'b1;

    do_hold(99, "boot");

    set_maps(5'h1F, 5'h1F, 5'h00, 5'h1F);
    fire(1'b1, 1'b0, "to_right");
    check("is_right", randomkeycode, 8'h04);

    set_maps(5'h00, 5'h1F, 5'h1F, 5'h1F);
    fire(1'b0, 1'b1, "fallback_rev");
    check("fb_left", randomkeycode, 8'h1A);

    set_maps(5'h1F, 5'h00, 5'h1F, 5'h1F);
    fire(1'b1, 1'b0, "to_up");

    set_maps(5'h00, 5'h00, 5'h1F, 5'h1F);
    for (int i = 0; i < 200; i++) begin
      fire(1'b1, 1'b0, "no_rev");
      check("legal", (randomkeycode == 8'h16) ||
                     (randomkeycode == 8'h1A), 1'b1);
    end

    set_maps(5'h00, 5'h1F, 5'h1F, 5'h1F);
    fire(1'b1, 1'b0, "to_left");
    set_maps(5'h1F, 5'h1F, 5'h1F, 5'h1F);
    fire(1'b0, 1'b1, "dead_end");
    check("none", randomkeycode, 8'h00);

    set_maps(5'h00, 5'h1F, 5'h1F, 5'h1F);
    fire(1'b1, 1'b0, "to_left2");
    ghostX = 10'd8;
    ghostY = 10'd200;
    mapL = 5'h1F;
    @(negedge Clk);
    sec = 1'b1;
    frame_tick = 1'b1;
    @(negedge Clk);
    sec = 1'b0;
    frame_tick = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      check("tunnel_hold", randomkeycode, 8'h1A);
    end
    ghostX = 10'd11;
    mapT = 5'h00;
    fire(1'b1, 1'b0, "tunnel_exit");
    check("exit_up", randomkeycode, 8'h16);

    set_maps(5'h1F, 5'h1F, 5'h1F, 5'h1F);
    @(negedge Clk);
    sec = 1'b1;
    @(negedge Clk);
    sec = 1'b0;
    repeat (2) @(negedge Clk);
    check("mid_choose", randomkeycode, 8'h16);
    do_restart("restart_k2");

    set_maps(5'h00, 5'h00, 5'h00, 5'h00);
    do_hold(2, "runA");
    run_a[0] = randomkeycode;
    for (int i = 1; i < 5; i++) begin
      fire(1'b1, 1'b0, "runA");
      run_a[i] = randomkeycode;
    end

    do_restart("restart2");
    do_hold(2, "runB");
    check("repeat0", randomkeycode, run_a[0]);
    for (int i = 1; i < 5; i++) begin
      fire(1'b1, 1'b0, "runB");
      check("repeat", randomkeycode, run_a[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
